// File: rtl/pb_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pb_conditioner
// Purpose  : Multi-channel push-button conditioner: synchroniser, debouncer,
//            press/release pulses and long-press detection per channel.
//            Optional macro PB_AUTO_REPEAT_EN adds press auto-repeat in LONG.
// Revision : 1.0 - initial release
// ============================================================================
module pb_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int LONG_CYCLES     = 200000000,
    parameter int REPEAT_CYCLES   = 40000000
) (
    input  logic                clk_200_mhz,
    input  logic                PB_RST,
    input  logic [CHANNELS-1:0] pb_in,
    output logic [CHANNELS-1:0] pb_level,
    output logic [CHANNELS-1:0] pb_press,
    output logic [CHANNELS-1:0] pb_release,
    output logic [CHANNELS-1:0] pb_long,
    output logic [CHANNELS-1:0] pb_long_held
);

    localparam int c_deb_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_hold_w = $clog2(LONG_CYCLES + 1);
    localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_CYCLES - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_pressed = 2'd1;
    localparam logic [1:0] c_st_long    = 2'd2;

`ifdef PB_AUTO_REPEAT_EN
    localparam int c_rep_w = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);
`endif

    // Elaboration-time guards on the legal parameter ranges.
    generate
        if (CHANNELS < 1 || CHANNELS > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_shape
            $error("pb_conditioner: CHANNELS or SYNC_STAGES out of range");
        end
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_timing
            $error("pb_conditioner: timing parameters out of range");
        end
    endgenerate

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_deb_w-1:0]     r_deb_cnt;
        logic [c_hold_w-1:0]    r_hold_cnt;
        logic [1:0]             r_state;
        logic                   r_level;
        logic                   r_press;
        logic                   r_release;
        logic                   r_long;
        logic                   r_long_held;
        logic                   w_s;
        logic                   w_accept;
`ifdef PB_AUTO_REPEAT_EN
        logic [c_rep_w-1:0]     r_rep_cnt;
`endif

        assign w_s      = r_sync[SYNC_STAGES-1];
        // A level change is accepted on the edge after DEBOUNCE_CYCLES-1
        // consecutive mismatching cycles have already been counted.
        assign w_accept = (w_s != r_level) && (r_deb_cnt == c_deb_last);

        always_ff @(posedge clk_200_mhz) begin
            if (PB_RST) begin
                r_sync      <= '0;
                r_deb_cnt   <= '0;
                r_hold_cnt  <= '0;
                r_state     <= c_st_idle;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long      <= 1'b0;
                r_long_held <= 1'b0;
`ifdef PB_AUTO_REPEAT_EN
                r_rep_cnt   <= '0;
`endif
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], pb_in[i]};
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;

                if (w_s == r_level) begin
                    r_deb_cnt <= '0;
                end else if (w_accept) begin
                    r_deb_cnt <= '0;
                    r_level   <= w_s;
                end else begin
                    r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
                end

                case (r_state)
                    c_st_idle: begin
                        if (w_accept && w_s) begin
                            r_state    <= c_st_pressed;
                            r_press    <= 1'b1;
                            r_hold_cnt <= '0;
                        end
                    end
                    c_st_pressed: begin
                        if (w_accept && !w_s) begin
                            r_state   <= c_st_idle;
                            r_release <= 1'b1;
                        end else if (r_hold_cnt == c_hold_last) begin
                            r_state     <= c_st_long;
                            r_long      <= 1'b1;
                            r_long_held <= 1'b1;
`ifdef PB_AUTO_REPEAT_EN
                            r_rep_cnt   <= '0;
`endif
                        end else begin
                            r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
                        end
                    end
                    c_st_long: begin
                        // Hold counter stays frozen here, so pb_long cannot recur.
                        if (w_accept && !w_s) begin
                            r_state     <= c_st_idle;
                            r_release   <= 1'b1;
                            r_long_held <= 1'b0;
                        end
`ifdef PB_AUTO_REPEAT_EN
                        else if (r_rep_cnt == c_rep_last) begin
                            r_press   <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
                        end
`endif
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end

        assign pb_level[i]     = r_level;
        assign pb_press[i]     = r_press;
        assign pb_release[i]   = r_release;
        assign pb_long[i]      = r_long;
        assign pb_long_held[i] = r_long_held;
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_conditioner
// Purpose  : Self-checking scoreboard bench for pb_conditioner (directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_conditioner;

    localparam int CHANNELS        = 2;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LONG_CYCLES     = 20;
    localparam int REPEAT_CYCLES   = 8;

    localparam int c_k_press   = 0;
    localparam int c_k_release = 1;
    localparam int c_k_long    = 2;
    localparam int c_k_reset   = 3;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    logic                clk_200_mhz = 1'b0;
    logic                PB_RST;
    logic [CHANNELS-1:0] pb_in;
    logic [CHANNELS-1:0] pb_level;
    logic [CHANNELS-1:0] pb_press;
    logic [CHANNELS-1:0] pb_release;
    logic [CHANNELS-1:0] pb_long;
    logic [CHANNELS-1:0] pb_long_held;

    ev_t                 q[$];
    int                  cyc      = 0;
    int                  checks   = 0;
    int                  failures = 0;
    bit                  mon_en   = 1'b0;
    logic [CHANNELS-1:0] exp_level = '0;
    logic [CHANNELS-1:0] exp_held  = '0;
    int                  t0;

    pb_conditioner #(
        .CHANNELS       (CHANNELS),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) dut (
        .clk_200_mhz (clk_200_mhz),
        .PB_RST      (PB_RST),
        .pb_in       (pb_in),
        .pb_level    (pb_level),
        .pb_press    (pb_press),
        .pb_release  (pb_release),
        .pb_long     (pb_long),
        .pb_long_held(pb_long_held)
    );

    always #5 clk_200_mhz = ~clk_200_mhz;
    always @(posedge clk_200_mhz) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_200_mhz);
        #1;
    endtask

    task automatic expect_ev(input int c, input int k, input int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        q.push_back(e);
    endtask

    function automatic bit take(input int c, input int k, input int ch);
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].cyc == c && q[j].kind == k && q[j].ch == ch) begin
                q.delete(j);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Monitor: pops expected events as the DUT presents pulses.
    initial begin
        string kn [3];
        bit    obs;
        bit    exp_hit;
        kn[0] = "press";
        kn[1] = "release";
        kn[2] = "long";
        forever begin
            @(negedge clk_200_mhz);
            if (mon_en) begin
                if (take(cyc, c_k_reset, 0)) begin
                    checks++;
                    if ({pb_level, pb_press, pb_release, pb_long, pb_long_held} !== '0) begin
                        failures++;
                        $display("FAIL reset_state cyc=%0d got=%b exp=0", cyc,
                                 {pb_level, pb_press, pb_release, pb_long, pb_long_held});
                    end
                    exp_level = '0;
                    exp_held  = '0;
                end
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    for (int k = 0; k < 3; k++) begin
                        obs     = (k == c_k_press)   ? pb_press[ch] :
                                  (k == c_k_release) ? pb_release[ch] : pb_long[ch];
                        exp_hit = take(cyc, k, ch);
                        if (obs || exp_hit) begin
                            checks++;
                            if (obs !== exp_hit) begin
                                failures++;
                                $display("FAIL pulse_%s ch=%0d cyc=%0d got=%0b exp=%0b",
                                         kn[k], ch, cyc, obs, exp_hit);
                            end
                        end
                        if (exp_hit) begin
                            if (k == c_k_press) exp_level[ch] = 1'b1;
                            if (k == c_k_release) begin
                                exp_level[ch] = 1'b0;
                                exp_held[ch]  = 1'b0;
                            end
                            if (k == c_k_long) exp_held[ch] = 1'b1;
                        end
                    end
                end
                checks++;
                if (pb_level !== exp_level || pb_long_held !== exp_held) begin
                    failures++;
                    $display("FAIL levels cyc=%0d got level=%b held=%b exp level=%b held=%b",
                             cyc, pb_level, pb_long_held, exp_level, exp_held);
                end
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (q[j].cyc < cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL missed_event kind=%0d ch=%0d got=none exp_cyc=%0d",
                                 q[j].kind, q[j].ch, q[j].cyc);
                        q.delete(j);
                    end
                end
            end
        end
    end

    initial begin
        PB_RST = 1'b1;
        pb_in  = '0;
        tick(2);
        expect_ev(cyc, c_k_reset, 0);
        mon_en = 1'b1;
        PB_RST = 1'b0;
        tick(3);

        // Clean press on ch0, channel 1 idle.
        t0 = cyc;
        pb_in[0] = 1'b1;
        expect_ev(t0 + 6, c_k_press, 0);
        tick(12);
        pb_in[0] = 1'b0;
        expect_ev(t0 + 18, c_k_release, 0);
        tick(12);

        // Bounce: runs of at most three highs are rejected.
        t0 = cyc;
        begin
            int pat [8];
            pat = '{1, 1, 1, 0, 0, 1, 1, 0};
            for (int k = 0; k < 8; k++) begin
                pb_in[0] = pat[k][0];
                tick(1);
            end
        end
        pb_in[0] = 1'b1;
        expect_ev(t0 + 14, c_k_press, 0);
        tick(6);
        pb_in[0] = 1'b0;
        expect_ev(t0 + 20, c_k_release, 0);
        tick(12);

        // Long press held 40 cycles.
        t0 = cyc;
        pb_in[0] = 1'b1;
        expect_ev(t0 + 6, c_k_press, 0);
        expect_ev(t0 + 26, c_k_long, 0);
`ifdef PB_AUTO_REPEAT_EN
        expect_ev(t0 + 34, c_k_press, 0);
        expect_ev(t0 + 42, c_k_press, 0);
`endif
        tick(40);
        pb_in[0] = 1'b0;
        expect_ev(t0 + 46, c_k_release, 0);
        tick(12);

        // Both channels, staggered and independent.
        t0 = cyc;
        pb_in[0] = 1'b1;
        expect_ev(t0 + 6, c_k_press, 0);
        tick(3);
        pb_in[1] = 1'b1;
        expect_ev(t0 + 9, c_k_press, 1);
        tick(7);
        pb_in[0] = 1'b0;
        expect_ev(t0 + 16, c_k_release, 0);
        tick(4);
        pb_in[1] = 1'b0;
        expect_ev(t0 + 20, c_k_release, 1);
        tick(12);

        // Reset mid-press, button still held afterwards.
        t0 = cyc;
        pb_in[0] = 1'b1;
        expect_ev(t0 + 6, c_k_press, 0);
        tick(10);
        PB_RST = 1'b1;
        expect_ev(t0 + 11, c_k_reset, 0);
        tick(1);
        PB_RST = 1'b0;
        expect_ev(t0 + 17, c_k_press, 0);
        tick(9);
        pb_in[0] = 1'b0;
        expect_ev(t0 + 26, c_k_release, 0);
        tick(12);

        // Three-cycle dip during hold must not reset the long-press timer.
        t0 = cyc;
        pb_in[0] = 1'b1;
        expect_ev(t0 + 6, c_k_press, 0);
        expect_ev(t0 + 26, c_k_long, 0);
`ifdef PB_AUTO_REPEAT_EN
        expect_ev(t0 + 34, c_k_press, 0);
`endif
        tick(12);
        pb_in[0] = 1'b0;
        tick(3);
        pb_in[0] = 1'b1;
        tick(15);
        pb_in[0] = 1'b0;
        expect_ev(t0 + 36, c_k_release, 0);
        tick(12);

        // Hold 50 cycles: repeats only when auto-repeat is built in.
        t0 = cyc;
        pb_in[0] = 1'b1;
        expect_ev(t0 + 6, c_k_press, 0);
        expect_ev(t0 + 26, c_k_long, 0);
`ifdef PB_AUTO_REPEAT_EN
        expect_ev(t0 + 34, c_k_press, 0);
        expect_ev(t0 + 42, c_k_press, 0);
        expect_ev(t0 + 50, c_k_press, 0);
`endif
        tick(50);
        pb_in[0] = 1'b0;
        expect_ev(t0 + 56, c_k_release, 0);
        tick(15);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
